// File: rtl/addsub_divider_seq.sv
// Sequential unsigned restoring divider that shares a single add/sub datapath.
// One trial subtraction is done per clock, for n clocks. After that the quotient
// and remainder are loaded and done pulses for one cycle.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 request, sampled only in IDLE
//   dividend, divisor     operands, captured on an accepted start
//   busy                  high while iterating (CALC)
//   done                  one-cycle pulse when the results become valid
//   quotient, remainder   results, held until the next load or reset
//   div_by_zero           set when the captured divisor was zero

// n-bit adder/subtractor: s = x + y (add_n=0) or x - y (add_n=1).
// c_out=1 on subtract means no borrow.
module adder_subtactor_nbit #(
    parameter int unsigned n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         add_n,
    output logic [n-1:0] s,
    output logic         c_out
);
    localparam int unsigned W = n + 1;

    logic [n-1:0] y_eff;

    assign y_eff        = add_n ? ~y : y;
    assign {c_out, s}   = {1'b0, x} + {1'b0, y_eff} + W'(add_n);
endmodule

module addsub_divider_seq #(
    parameter int unsigned n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_by_zero
);
    localparam int unsigned CW = $clog2(n) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [n-1:0]  q_reg;
    logic [n-1:0]  d_reg;
    logic [n:0]    r_reg;
    logic [CW-1:0] count;

    logic [n:0]    shifted;
    logic [n:0]    diff;
    logic          no_borrow;
    logic [n:0]    step_r;
    logic [n-1:0]  step_q;
    logic          last_step;
    logic          r_unused;

    // Shift the next dividend bit into the partial remainder, then trial-subtract D.
    assign shifted = {r_reg[n-1:0], q_reg[n-1]};

    adder_subtactor_nbit #(.n(n + 1)) u_addsub (
        .x     (shifted),
        .y     ({1'b0, d_reg}),
        .add_n (1'b1),
        .s     (diff),
        .c_out (no_borrow)
    );

    // Restoring step: keep the difference only when it did not go negative.
    assign step_r    = no_borrow ? diff : shifted;
    assign step_q    = {q_reg[n-2:0], no_borrow};
    assign last_step = (count == CW'(n - 1));

    // After a step R < D, so the top bit of R stays zero.
    assign r_unused  = r_reg[n];

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and result registers; busy/done mirror the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_next == S_CALC);
            done <= (state_next == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            q_reg       <= dividend;
                            d_reg       <= divisor;
                            r_reg       <= '0;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_reg <= step_r;
                    q_reg <= step_q;
                    count <= count + CW'(1);
                    if (last_step) begin
                        quotient  <= step_q;
                        remainder <= step_r[n-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_divider_seq.sv
// Self-checking bench for addsub_divider_seq: a 4-bit instance driven from a
// vector table plus corner sequences, and an 8-bit instance for a random sweep.
module tb_addsub_divider_seq;
    typedef struct {
        int unsigned dvd;
        int unsigned dvs;
        int unsigned q;
        int unsigned r;
        bit          dbz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       a_start;
    logic [3:0] a_dividend, a_divisor, a_quotient, a_remainder;
    logic       a_busy, a_done, a_dbz;

    logic       b_start;
    logic [7:0] b_dividend, b_divisor, b_quotient, b_remainder;
    logic       b_busy, b_done, b_dbz;

    int n_cmp = 0;
    int n_bad = 0;
    int a_dcnt = 0;
    int b_dcnt = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t vecs[10];

    always #5 clk = ~clk;

    addsub_divider_seq #(.n(4)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .dividend(a_dividend), .divisor(a_divisor),
        .busy(a_busy), .done(a_done), .quotient(a_quotient), .remainder(a_remainder),
        .div_by_zero(a_dbz)
    );

    addsub_divider_seq #(.n(8)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .dividend(b_dividend), .divisor(b_divisor),
        .busy(b_busy), .done(b_done), .quotient(b_quotient), .remainder(b_remainder),
        .div_by_zero(b_dbz)
    );

    // Count every done pulse so duplicate or missing pulses are visible.
    always @(posedge clk) begin
        if (a_done) a_dcnt <= a_dcnt + 1;
        if (b_done) b_dcnt <= b_dcnt + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model8(input int unsigned dvd, input int unsigned dvs);
        exp_t e;
        e.dvd = dvd;
        e.dvs = dvs;
        if (dvs == 0) begin
            e.q   = 255;
            e.r   = dvd;
            e.dbz = 1'b1;
        end else begin
            e.q   = dvd / dvs;
            e.r   = dvd % dvs;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // One full operation; the DUT must be in IDLE on entry and is back in IDLE on exit.
    task automatic run_op(input exp_t e, input bit w8, input bit scramble);
        int unsigned nn;
        int          edges;
        int          dc0;
        exp_t        got;
        nn = w8 ? 8 : 4;
        @(posedge clk); #1;
        if (w8) begin
            b_start = 1'b1; b_dividend = 8'(e.dvd); b_divisor = 8'(e.dvs);
            qb.push_back(e); dc0 = b_dcnt;
        end else begin
            a_start = 1'b1; a_dividend = 4'(e.dvd); a_divisor = 4'(e.dvs);
            qa.push_back(e); dc0 = a_dcnt;
        end
        @(posedge clk); #1;
        a_start = 1'b0;
        b_start = 1'b0;
        if (scramble) begin
            a_dividend = 4'($urandom); a_divisor = 4'($urandom);
            b_dividend = 8'($urandom); b_divisor = 8'($urandom);
        end
        if (!e.dbz) chk("busy_after_accept", w8 ? b_busy : a_busy, 1);
        edges = 0;
        while (!(w8 ? b_done : a_done) && edges < int'(4 * nn)) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency_edges", edges, e.dbz ? 0 : nn);
        if (w8) got = qb.pop_front(); else got = qa.pop_front();
        if (w8 ? b_done : a_done) begin
            chk("quotient", w8 ? b_quotient : a_quotient, got.q);
            chk("remainder", w8 ? b_remainder : a_remainder, got.r);
            chk("div_by_zero", w8 ? b_dbz : a_dbz, got.dbz);
            chk("busy_in_done", w8 ? b_busy : a_busy, 0);
            if (w8 && !got.dbz) begin
                chk("invariant", b_quotient * got.dvs + b_remainder, got.dvd);
                chk("rem_lt_divisor", (b_remainder < got.dvs) ? 1 : 0, 1);
            end
        end
        @(posedge clk); #1;
        chk("done_single_cycle", w8 ? b_done : a_done, 0);
        chk("done_count", (w8 ? b_dcnt : a_dcnt) - dc0, 1);
    endtask

    initial begin
        exp_t e;
        int   dc0;
        int   edges;
        int unsigned sp_dvd[6];
        int unsigned sp_dvs[6];

        vecs[0] = '{13, 3, 4, 1, 1'b0};
        vecs[1] = '{15, 1, 15, 0, 1'b0};
        vecs[2] = '{7, 9, 0, 7, 1'b0};
        vecs[3] = '{10, 0, 15, 10, 1'b1};
        vecs[4] = '{6, 2, 3, 0, 1'b0};
        vecs[5] = '{0, 5, 0, 0, 1'b0};
        vecs[6] = '{15, 15, 1, 0, 1'b0};
        vecs[7] = '{1, 15, 0, 1, 1'b0};
        vecs[8] = '{8, 2, 4, 0, 1'b0};
        vecs[9] = '{14, 4, 3, 2, 1'b0};

        rst = 1'b1;
        a_start = 1'b0; a_dividend = '0; a_divisor = '0;
        b_start = 1'b0; b_dividend = '0; b_divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_quotient", a_quotient, 0);
        chk("rst_remainder", a_remainder, 0);
        chk("rst_dbz", a_dbz, 0);
        chk("rst_b_busy", b_busy, 0);
        rst = 1'b0;

        // Table-driven vectors on the 4-bit instance.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], 1'b0, (i % 2) == 1);
        end

        // Results hold in IDLE.
        repeat (3) @(posedge clk);
        #1;
        chk("hold_quotient_idle", a_quotient, 3);
        chk("hold_remainder_idle", a_remainder, 2);

        // start and operand changes during CALC are ignored; start in DONE is ignored.
        @(posedge clk); #1;
        a_start = 1'b1; a_dividend = 4'd13; a_divisor = 4'd3;
        qa.push_back('{13, 3, 4, 1, 1'b0});
        dc0 = a_dcnt;
        @(posedge clk); #1;
        a_start = 1'b0;
        @(posedge clk); #1;
        a_start = 1'b1; a_dividend = 4'd2; a_divisor = 4'd1;
        chk("hold_quotient_calc", a_quotient, 3);
        chk("hold_remainder_calc", a_remainder, 2);
        @(posedge clk); #1;
        a_dividend = 4'd5; a_divisor = 4'd7;
        @(posedge clk); #1;
        a_start = 1'b0;
        edges = 0;
        while (!a_done && edges < 16) begin
            @(posedge clk); #1;
            edges++;
        end
        e = qa.pop_front();
        chk("ign_done_seen", a_done, 1);
        chk("ign_quotient", a_quotient, e.q);
        chk("ign_remainder", a_remainder, e.r);
        a_start = 1'b1; a_dividend = 4'd9; a_divisor = 4'd2;
        @(posedge clk); #1;
        a_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ign_start_in_done", a_busy, 0);
        chk("ign_done_count", a_dcnt - dc0, 1);
        chk("ign_quotient_kept", a_quotient, 4);

        // Reset in the middle of an operation aborts it with no done pulse.
        @(posedge clk); #1;
        a_start = 1'b1; a_dividend = 4'd13; a_divisor = 4'd3;
        @(posedge clk); #1;
        a_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", a_busy, 0);
        chk("abort_done", a_done, 0);
        chk("abort_quotient", a_quotient, 0);
        chk("abort_remainder", a_remainder, 0);
        chk("abort_dbz", a_dbz, 0);
        dc0 = a_dcnt;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", a_dcnt - dc0, 0);
        chk("abort_idle", a_busy, 0);
        run_op('{9, 4, 2, 1, 1'b0}, 1'b0, 1'b0);

        // 8-bit sweep: corner operands first, then random.
        sp_dvd = '{200, 0, 17, 255, 100, 255};
        sp_dvs = '{1, 37, 200, 255, 0, 1};
        for (int i = 0; i < 6; i++) begin
            run_op(model8(sp_dvd[i], sp_dvs[i]), 1'b1, 1'b1);
        end
        for (int i = 0; i < 1000; i++) begin
            int unsigned dvd;
            int unsigned dvs;
            dvd = $urandom_range(0, 255);
            dvs = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 255);
            run_op(model8(dvd, dvs), 1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
